// File: rtl/crypto_sm3_inv.sv
// crypto_sm3_inv: multi-cycle inverse of the SM3 P0/P1 permutations.
//
// P0(x) = x ^ rol32(x,9)  ^ rol32(x,17)
// P1(x) = x ^ rol32(x,15) ^ rol32(x,23)
// Both satisfy P^32 = identity, so applying P 31 times gives P^-1. The block latches a
// 32-bit word, applies the selected P ITERATIONS times, and returns the 32-bit result
// sign-extended to XLEN through a valid/ready handshake.
//
// Optional build macro: CRYPTO_SM3_INV_UNROLL2_EN
//   Defined   -> two P applications per RUN cycle (ceil(ITERATIONS/2) cycles).
//   Undefined -> one P application per RUN cycle (ITERATIONS cycles).
//   Results are identical in both builds.
//
// Parameters:
//   ITERATIONS : number of P applications, legal range 1..31 (31 = inverse, 1 = forward)
//   XLEN       : datapath width, 32 or 64
//
// Ports:
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   flush_i   : synchronous abort; returns to idle, no result produced
//   valid_i   : request valid
//   ready_o   : block can accept a request (idle)
//   op_i      : 0 = P0, 1 = P1
//   rs1_i     : operand, only bits [31:0] used
//   valid_o   : result valid
//   ready_i   : consumer accepts result
//   result_o  : sign-extended 32-bit result, zero when valid_o is low

module crypto_sm3_inv #(
  parameter int unsigned ITERATIONS = 31,
  parameter int unsigned XLEN       = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            op_i,
  input  logic [XLEN-1:0] rs1_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam logic [4:0] IterCnt = 5'(ITERATIONS);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic        op_q, op_d;
  logic        run_last;
  logic        accept;
  logic [XLEN-1:0] acc_ext;

  function automatic logic [31:0] sm3_p0(input logic [31:0] x);
    return x ^ {x[22:0], x[31:23]} ^ {x[14:0], x[31:15]};
  endfunction

  function automatic logic [31:0] sm3_p1(input logic [31:0] x);
    return x ^ {x[16:0], x[31:17]} ^ {x[8:0], x[31:9]};
  endfunction

  function automatic logic [31:0] sm3_p(input logic op, input logic [31:0] x);
    return op ? sm3_p1(x) : sm3_p0(x);
  endfunction

  // flush_i wins over a simultaneous request
  assign accept = (state_q == StIdle) && valid_i && !flush_i;

`ifdef CRYPTO_SM3_INV_UNROLL2_EN
  // cnt 2 or 1 means this cycle finishes the remaining applications
  assign run_last = (cnt_q <= 5'd2);
`else
  assign run_last = (cnt_q == 5'd1);
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept)   state_d = StRun;
      StRun:   if (run_last) state_d = StDone;
      StDone:  if (ready_i)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush_i) begin
      state_d = StIdle;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      acc_q <= '0;
      op_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      op_q  <= op_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    op_d  = op_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          acc_d = rs1_i[31:0];
          op_d  = op_i;
          cnt_d = IterCnt;
        end
      end
      StRun: begin
`ifdef CRYPTO_SM3_INV_UNROLL2_EN
        if (cnt_q >= 5'd2) begin
          acc_d = sm3_p(op_q, sm3_p(op_q, acc_q));
          cnt_d = cnt_q - 5'd2;
        end else begin
          acc_d = sm3_p(op_q, acc_q);
          cnt_d = cnt_q - 5'd1;
        end
`else
        acc_d = sm3_p(op_q, acc_q);
        cnt_d = cnt_q - 5'd1;
`endif
      end
      default: ;
    endcase
  end

  // Sign extension; upper operand bits are intentionally ignored
  if (XLEN > 32) begin : gen_sext
    logic unused_rs1_hi;
    assign unused_rs1_hi = ^rs1_i[XLEN-1:32];
    assign acc_ext = {{(XLEN-32){acc_q[31]}}, acc_q};
  end else begin : gen_nosext
    assign acc_ext = acc_q;
  end

  // Output logic
  always_comb begin
    ready_o  = (state_q == StIdle);
    valid_o  = (state_q == StDone);
    result_o = valid_o ? acc_ext : '0;
  end

endmodule

// File: tb/tb_crypto_sm3_inv.sv
// Self-checking bench for crypto_sm3_inv: table vectors, flush/reset/backpressure
// sequences, and a random forward/inverse round-trip against a behavioural model.
module tb_crypto_sm3_inv;

  logic        clk;
  logic        rst_n;

  logic        a_flush, a_valid, a_ready, a_op, a_valid_o, a_ready_i;
  logic [63:0] a_rs1, a_res;
  logic        f_flush, f_valid, f_ready, f_op, f_valid_o, f_ready_i;
  logic [63:0] f_rs1, f_res;

  int n_checks = 0;
  int n_errors = 0;

  crypto_sm3_inv #(.ITERATIONS(31), .XLEN(64)) u_inv (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (a_flush),
    .valid_i (a_valid),
    .ready_o (a_ready),
    .op_i    (a_op),
    .rs1_i   (a_rs1),
    .valid_o (a_valid_o),
    .ready_i (a_ready_i),
    .result_o(a_res)
  );

  crypto_sm3_inv #(.ITERATIONS(1), .XLEN(64)) u_fwd (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (f_flush),
    .valid_i (f_valid),
    .ready_o (f_ready),
    .op_i    (f_op),
    .rs1_i   (f_rs1),
    .valid_o (f_valid_o),
    .ready_i (f_ready_i),
    .result_o(f_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] rol(input logic [31:0] a, input int n);
    logic [31:0] l, r;
    l = a << n;
    r = a >> (32 - n);
    return l | r;
  endfunction

  function automatic logic [31:0] p_model(input logic op, input logic [31:0] x);
    if (op) return x ^ rol(x, 15) ^ rol(x, 23);
    return x ^ rol(x, 9) ^ rol(x, 17);
  endfunction

  function automatic logic [63:0] sext(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic int exp_lat(input int n);
`ifdef CRYPTO_SM3_INV_UNROLL2_EN
    return (n + 1) / 2;
`else
    return n;
`endif
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic vo(input bit fwd);
    return fwd ? f_valid_o : a_valid_o;
  endfunction

  function automatic logic rdy(input bit fwd);
    return fwd ? f_ready : a_ready;
  endfunction

  function automatic logic [63:0] res_of(input bit fwd);
    return fwd ? f_res : a_res;
  endfunction

  // Issue one request, wait for the result, optionally hold ready_i low, then handshake.
  task automatic run_op(input bit fwd, input logic op, input logic [63:0] rs1, input int hold,
                        output logic [63:0] res, output int lat);
    logic rdy_bad, stable_bad;
    rdy_bad = 1'b0;
    chk("idle_ready", 64'(rdy(fwd)), 64'd1);
    if (fwd) begin f_valid = 1'b1; f_op = op; f_rs1 = rs1; end
    else     begin a_valid = 1'b1; a_op = op; a_rs1 = rs1; end
    @(posedge clk); #1;
    // Operands change after acceptance; they must have no effect.
    if (fwd) begin f_valid = 1'b0; f_op = ~op; f_rs1 = {$urandom, $urandom}; end
    else     begin a_valid = 1'b0; a_op = ~op; a_rs1 = {$urandom, $urandom}; end
    lat = 0;
    do begin
      if (rdy(fwd)) rdy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end while (!vo(fwd) && lat < 100);
    chk("run_ready_low", 64'(rdy_bad), 64'd0);
    res = res_of(fwd);
    if (hold > 0) begin
      stable_bad = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (!vo(fwd) || res_of(fwd) !== res || rdy(fwd)) stable_bad = 1'b1;
      end
      chk("backpressure_stable", 64'(stable_bad), 64'd0);
    end
    if (fwd) f_ready_i = 1'b1; else a_ready_i = 1'b1;
    @(posedge clk); #1;
    if (fwd) f_ready_i = 1'b0; else a_ready_i = 1'b0;
    chk("post_handshake_vld_rdy", 64'({vo(fwd), rdy(fwd)}), 64'd1);
  endtask

  // Watch the inverse unit for a number of cycles; valid_o must never rise.
  task automatic expect_no_valid(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (a_valid_o) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  typedef struct {
    logic        op;
    logic [63:0] rs1;
    logic [63:0] exp;
    int          hold;
  } vec_t;

  vec_t        vecs[6];
  logic [63:0] res;
  int          lat;
  logic [31:0] x, px;

  initial begin
    vecs[0] = '{op: 1'b0, rs1: 64'hDEADBEEF_00020201, exp: 64'h0000_0000_0000_0001, hold: 0};
    vecs[1] = '{op: 1'b1, rs1: 64'h0000_0000_0080_8001, exp: 64'h0000_0000_0000_0001, hold: 0};
    vecs[2] = '{op: 1'b0, rs1: 64'h0000_0000_8001_0100, exp: 64'hFFFF_FFFF_8000_0000, hold: 10};
    vecs[3] = '{op: 1'b0, rs1: 64'h0000_0000_0000_0000, exp: 64'h0000_0000_0000_0000, hold: 0};
    vecs[4] = '{op: 1'b1, rs1: 64'hFFFF_FFFF_FFFF_FFFF, exp: 64'hFFFF_FFFF_FFFF_FFFF, hold: 3};
    vecs[5] = '{op: 1'b1, rs1: 64'h1234_5678_8040_4000, exp: 64'hFFFF_FFFF_8000_0000, hold: 0};

    rst_n = 1'b0;
    a_flush = 1'b0; a_valid = 1'b0; a_op = 1'b0; a_rs1 = '0; a_ready_i = 1'b0;
    f_flush = 1'b0; f_valid = 1'b0; f_op = 1'b0; f_rs1 = '0; f_ready_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 64'(a_valid_o), 64'd0);
    chk("reset_result", a_res, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_ready", 64'(a_ready), 64'd1);

    // Table-driven vectors on the inverse unit
    foreach (vecs[i]) begin
      run_op(1'b0, vecs[i].op, vecs[i].rs1, vecs[i].hold, res, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(31)));
    end

    // Forward (ITERATIONS=1) unit
    run_op(1'b1, 1'b0, 64'h0000_0000_0000_0001, 0, res, lat);
    chk("fwd_result", res, 64'h0000_0000_0002_0201);
    chk("fwd_latency", 64'(lat), 64'(exp_lat(1)));

    // Flush during RUN at T+10
    a_valid = 1'b1; a_op = 1'b0; a_rs1 = 64'h0000_0000_0002_0201;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    chk("flush_run_ready", 64'(a_ready), 64'd1);
    chk("flush_run_valid", 64'(a_valid_o), 64'd0);
    expect_no_valid("flush_run_no_result", 40);

    // Flush together with a request in IDLE: not accepted
    a_valid = 1'b1; a_flush = 1'b1; a_op = 1'b1; a_rs1 = 64'h0000_0000_0080_8001;
    @(posedge clk); #1;
    a_valid = 1'b0; a_flush = 1'b0;
    chk("flush_idle_ready", 64'(a_ready), 64'd1);
    expect_no_valid("flush_idle_no_result", 40);

    // Reset asserted mid-RUN
    a_valid = 1'b1; a_op = 1'b0; a_rs1 = 64'h0000_0000_0002_0201;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(a_valid_o), 64'd0);
    chk("rst_mid_result", a_res, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_mid_ready", 64'(a_ready), 64'd1);
    expect_no_valid("rst_mid_no_result", 40);
    run_op(1'b0, 1'b0, 64'h0000_0000_8001_0100, 0, res, lat);
    chk("after_rst_result", res, 64'hFFFF_FFFF_8000_0000);
    chk("after_rst_latency", 64'(lat), 64'(exp_lat(31)));

    // Random round trip: forward unit vs model, then inverse unit back to the original
    for (int op = 0; op < 2; op++) begin
      for (int k = 0; k < 1000; k++) begin
        x  = $urandom;
        px = p_model(op[0], x);
        run_op(1'b1, op[0], {$urandom, x}, 0, res, lat);
        chk("rand_fwd", res, sext(px));
        run_op(1'b0, op[0], {$urandom, px}, 0, res, lat);
        chk("rand_inv", res, sext(x));
        chk("rand_inv_latency", 64'(lat), 64'(exp_lat(31)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
